fpalu_seq: RTL and testbench
============================

Name: fpalu_seq

Overview:
- Issue/sequencer stage directly upstream of the FP ALU.
- The FP ALU's arithmetic cores are clocked pipelines, but its output mux selects combinationally on the opcode, so the opcode and operands must stay stable until the result is valid.
- fpalu_seq latches operands and opcode on a start pulse, drives them to the FP ALU, counts the per-op latency, captures result, compare bit and exception flags, and reports busy/done to the CPU stall logic.
- It also keeps sticky FP exception flags for the fcsr path.

Parameters:
- LAT_ADD, 7, FP ALU latency in cycles for FOPADD/FOPSUB.
- LAT_MUL, 5, latency for FOPMUL.
- LAT_DIV, 6, latency for FOPDIV.
- LAT_SQRT, 16, latency for FOPSQRT.
- LAT_CMP, 1, latency for FOPCEQ/FOPCLT/FOPCLE.
- LAT_CVT, 6, latency for FOPCVTSW/FOPCVTWS.
- All other opcodes (ABS, NEG, SGNJ*, undefined) use latency 0.

Ports:
- iclock  in  1  system clock.
- ireset  in  1  asynchronous active-high reset.
- istart  in  1  start pulse from decode; sampled only in IDLE.
- icontrol  in  5  FP opcode (FOP* encoding).
- idataa  in  32  operand A.
- idatab  in  32  operand B.
- ocontrol  out  5  latched opcode to the FP ALU.
- odataa  out  32  latched operand A to the FP ALU.
- odatab  out  32  latched operand B to the FP ALU.
- ialu_result  in  32  FP ALU result.
- ialu_nan  in  1  FP ALU nan flag.
- ialu_overflow  in  1  FP ALU overflow flag.
- ialu_underflow  in  1  FP ALU underflow flag.
- ialu_comp  in  1  FP ALU compare result.
- obusy  out  1  high while state != IDLE; drives the pipeline stall.
- odone  out  1  one-cycle pulse; oresult/ocomp valid this cycle.
- oresult  out  32  captured result, held until the next capture.
- ocomp  out  1  captured compare bit, held until the next capture.
- iflagclr  in  1  clear the sticky flags.
- oflags  out  3  sticky flags {NV, OF, UF}.

Behaviour:
- Reset: asynchronous, active-high, may assert mid-operation. State returns to IDLE. All outputs go to 0: ocontrol, odataa, odatab, oresult, ocomp, odone, obusy, oflags. The in-flight op is dropped with no capture.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On istart=1, latch icontrol/idataa/idatab into ocontrol/odataa/odatab.
  - Load cnt with LAT(icontrol) and go to WAIT.
  - cnt is 5 bits and saturates at the parameter value.
- WAIT:
  - ocontrol/odataa/odatab are held constant.
  - If cnt==0: capture ialu_result into oresult and ialu_comp into ocomp, OR the flags in, go to DONE.
  - Otherwise decrement cnt.
- DONE: odone=1 for exactly this cycle. Next state is IDLE unconditionally.
- Timing: istart at cycle T gives WAIT on cycles T+1..T+L+1 and odone at T+L+2. Total latency is L+2 cycles; an op with L=0 has odone at T+2.
- Back-to-back issue: the next istart is accepted no earlier than the cycle after DONE, i.e. when back in IDLE.
- istart while busy (WAIT or DONE) is ignored. The caller must hold it under obusy stall.
- Flag accumulation: the three flags are ORed in on capture only for ADD, SUB, MUL, DIV, SQRT and CVTWS.
  - SQRT contributes no UF (treated as 0).
  - Other ops never set flags.
- iflagclr clears oflags. If iflagclr and a capture occur in the same cycle, oflags = new flags (set wins over clear).
- Undefined opcode: latency 0; captures whatever the FP ALU presents (0 by its default case).

Optional Feature:
- Macro: FPSEQ_FLAGS_EN.
- Defined: sticky oflags register and iflagclr behave as specified above.
- Undefined: no flag register; oflags is tied to 3'b000 and iflagclr is ignored.
- Result, compare and timing behaviour are identical in both builds.

Decomposition:
- Shared package (Parametros.v): FOP* opcode constants and the state encodings ST_FPS_IDLE, ST_FPS_WAIT, ST_FPS_DONE.
- Latency parameter defaults live beside the FP core instantiation constants so that regenerating an IP core updates both together.
- One natural sub-module, fpalu_seq_lat: combinational opcode-to-latency lookup returning 5 bits.
- The FSM, counter and capture logic stay in fpalu_seq.

Test Plan:
- FOPADD, A=0x3F800000, B=0x40000000, istart at T (FP ALU model with LAT_ADD=7) -> odone at T+9, oresult=0x40400000, obusy high T+1..T+9, oflags=000.
- FOPNEG, A=0x40490FDB -> odone at T+2, oresult=0xC0490FDB; ocontrol/odataa stable throughout.
- FOPMUL, A=0x7F7FFFFF, B=0x40000000 -> odone at T+7, OF set and sticky. A following FOPCLT with A=1.0, B=2.0 -> ocomp=1 and oflags still 010.
- FOPSQRT started, ireset pulsed at T+5 -> all outputs 0 immediately, no odone. A new FOPADD issued afterwards completes normally.
- FOPDIV with nan model asserted and iflagclr in the capture cycle -> oflags=100 (set wins). iflagclr alone in a later cycle -> 000.
- istart re-pulsed during WAIT with a different opcode -> ignored; latched ocontrol and the odone timing are unchanged.

Source files
------------

// File: rtl/fpalu_seq_pkg.sv
// Shared FP sequencer definitions: FOP* opcode encoding, sequencer state encoding,
// default FP core latencies (kept together so an IP core regeneration updates both).
package fpalu_seq_pkg;

  localparam logic [4:0] FOPADD   = 5'd0;
  localparam logic [4:0] FOPSUB   = 5'd1;
  localparam logic [4:0] FOPMUL   = 5'd2;
  localparam logic [4:0] FOPDIV   = 5'd3;
  localparam logic [4:0] FOPSQRT  = 5'd4;
  localparam logic [4:0] FOPABS   = 5'd5;
  localparam logic [4:0] FOPNEG   = 5'd6;
  localparam logic [4:0] FOPCEQ   = 5'd7;
  localparam logic [4:0] FOPCLT   = 5'd8;
  localparam logic [4:0] FOPCLE   = 5'd9;
  localparam logic [4:0] FOPCVTSW = 5'd10;
  localparam logic [4:0] FOPCVTWS = 5'd11;
  localparam logic [4:0] FOPSGNJ  = 5'd12;
  localparam logic [4:0] FOPSGNJN = 5'd13;
  localparam logic [4:0] FOPSGNJX = 5'd14;

  localparam int LAT_ADD_DEF  = 7;
  localparam int LAT_MUL_DEF  = 5;
  localparam int LAT_DIV_DEF  = 6;
  localparam int LAT_SQRT_DEF = 16;
  localparam int LAT_CMP_DEF  = 1;
  localparam int LAT_CVT_DEF  = 6;

  typedef enum logic [1:0] {
    ST_FPS_IDLE = 2'd0,
    ST_FPS_WAIT = 2'd1,
    ST_FPS_DONE = 2'd2
  } fps_state_t;

  // The 5-bit latency counter cannot represent more than 31 cycles.
  function automatic logic [4:0] sat5(input int v);
    logic [31:0] vb;
    vb = v;
    if (v > 31) return 5'd31;
    if (v < 0) return 5'd0;
    return vb[4:0];
  endfunction

  // Ops whose exception flags feed the sticky fcsr flags.
  function automatic logic op_sets_flags(input logic [4:0] op);
    return (op == FOPADD) || (op == FOPSUB) || (op == FOPMUL) ||
           (op == FOPDIV) || (op == FOPSQRT) || (op == FOPCVTWS);
  endfunction

endpackage

// File: rtl/fpalu_seq_lat.sv
// Combinational opcode-to-latency lookup for the FP ALU sequencer.
module fpalu_seq_lat
  import fpalu_seq_pkg::*;
#(
  parameter int LAT_ADD  = LAT_ADD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int LAT_SQRT = LAT_SQRT_DEF,
  parameter int LAT_CMP  = LAT_CMP_DEF,
  parameter int LAT_CVT  = LAT_CVT_DEF
) (
  input  logic [4:0] op,
  output logic [4:0] lat
);

  localparam logic [4:0] L_ADD  = sat5(LAT_ADD);
  localparam logic [4:0] L_MUL  = sat5(LAT_MUL);
  localparam logic [4:0] L_DIV  = sat5(LAT_DIV);
  localparam logic [4:0] L_SQRT = sat5(LAT_SQRT);
  localparam logic [4:0] L_CMP  = sat5(LAT_CMP);
  localparam logic [4:0] L_CVT  = sat5(LAT_CVT);

  always_comb begin
    lat = 5'd0;
    case (op)
      FOPADD, FOPSUB:              lat = L_ADD;
      FOPMUL:                      lat = L_MUL;
      FOPDIV:                      lat = L_DIV;
      FOPSQRT:                     lat = L_SQRT;
      FOPCEQ, FOPCLT, FOPCLE:      lat = L_CMP;
      FOPCVTSW, FOPCVTWS:          lat = L_CVT;
      default:                     lat = 5'd0;
    endcase
  end

endmodule

// File: rtl/fpalu_seq.sv
// FP ALU issue sequencer: latches op/operands, waits the per-op latency, captures result.
// Sticky exception flags exist only when FPSEQ_FLAGS_EN is defined; otherwise oflags is 0.
module fpalu_seq
  import fpalu_seq_pkg::*;
#(
  parameter int LAT_ADD  = LAT_ADD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int LAT_SQRT = LAT_SQRT_DEF,
  parameter int LAT_CMP  = LAT_CMP_DEF,
  parameter int LAT_CVT  = LAT_CVT_DEF
) (
  input  logic        iclock,
  input  logic        ireset,
  input  logic        istart,
  input  logic [4:0]  icontrol,
  input  logic [31:0] idataa,
  input  logic [31:0] idatab,
  output logic [4:0]  ocontrol,
  output logic [31:0] odataa,
  output logic [31:0] odatab,
  input  logic [31:0] ialu_result,
  input  logic        ialu_nan,
  input  logic        ialu_overflow,
  input  logic        ialu_underflow,
  input  logic        ialu_comp,
  output logic        obusy,
  output logic        odone,
  output logic [31:0] oresult,
  output logic        ocomp,
  input  logic        iflagclr,
  output logic [2:0]  oflags
);

  fps_state_t state, state_nxt;
  logic [4:0] cnt;
  logic [4:0] lat;
  logic       capture;

  fpalu_seq_lat #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_SQRT(LAT_SQRT),
    .LAT_CMP (LAT_CMP),
    .LAT_CVT (LAT_CVT)
  ) u_lat (
    .op (icontrol),
    .lat(lat)
  );

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) state <= ST_FPS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    obusy     = 1'b0;
    odone     = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_FPS_IDLE: begin
        if (istart) state_nxt = ST_FPS_WAIT;
      end
      ST_FPS_WAIT: begin
        obusy = 1'b1;
        if (cnt == 5'd0) begin
          capture   = 1'b1;
          state_nxt = ST_FPS_DONE;
        end
      end
      ST_FPS_DONE: begin
        obusy     = 1'b1;
        odone     = 1'b1;
        state_nxt = ST_FPS_IDLE;
      end
      default: state_nxt = ST_FPS_IDLE;
    endcase
  end

  // The ALU output mux is combinational on ocontrol, so operands only change in IDLE.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      cnt      <= 5'd0;
      ocontrol <= 5'd0;
      odataa   <= 32'd0;
      odatab   <= 32'd0;
      oresult  <= 32'd0;
      ocomp    <= 1'b0;
    end else begin
      if (state == ST_FPS_IDLE && istart) begin
        ocontrol <= icontrol;
        odataa   <= idataa;
        odatab   <= idatab;
        cnt      <= lat;
      end else if (state == ST_FPS_WAIT && cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
      end
      if (capture) begin
        oresult <= ialu_result;
        ocomp   <= ialu_comp;
      end
    end
  end

`ifdef FPSEQ_FLAGS_EN
  logic [2:0] flags_q;
  logic [2:0] new_flags;

  always_comb begin
    new_flags = 3'b000;
    if (op_sets_flags(ocontrol))
      new_flags = {ialu_nan, ialu_overflow, (ocontrol == FOPSQRT) ? 1'b0 : ialu_underflow};
  end

  // A capture in the same cycle as a clear leaves only the newly raised flags.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset)        flags_q <= 3'b000;
    else if (capture)  flags_q <= (iflagclr ? 3'b000 : flags_q) | new_flags;
    else if (iflagclr) flags_q <= 3'b000;
  end

  assign oflags = flags_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{iflagclr, ialu_nan, ialu_overflow, ialu_underflow};
  assign oflags = 3'b000;
`endif

endmodule

// File: tb/tb_fpalu_seq.sv
// Scoreboard bench for fpalu_seq with a latency-aware FP ALU stand-in.
module tb_fpalu_seq;
  import fpalu_seq_pkg::*;

`ifdef FPSEQ_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        iclock = 1'b0;
  logic        ireset;
  logic        istart;
  logic [4:0]  icontrol;
  logic [31:0] idataa, idatab;
  logic [4:0]  ocontrol;
  logic [31:0] odataa, odatab;
  logic [31:0] ialu_result;
  logic        ialu_nan, ialu_overflow, ialu_underflow, ialu_comp;
  logic        obusy, odone;
  logic [31:0] oresult;
  logic        ocomp;
  logic        iflagclr;
  logic [2:0]  oflags;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        comp;
    logic [2:0]  flags;
    int          cyc;
  } sb_t;
  sb_t sb[$];
  logic [2:0] exp_flags = 3'b000;

  // FP ALU stand-in: real result only once the op has been in flight for its latency.
  logic [31:0] m_res;
  logic        m_comp, m_nan, m_of, m_uf;
  int          cur_lat = 0;
  int          age = 0;
  logic        ready;

  always @(posedge iclock) begin
    cyc <= cyc + 1;
    age <= obusy ? age + 1 : 0;
  end
  assign ready          = obusy && (age >= cur_lat);
  assign ialu_result    = ready ? m_res  : 32'hDEADBEEF;
  assign ialu_comp      = ready ? m_comp : ~m_comp;
  assign ialu_nan       = ready ? m_nan  : 1'b1;
  assign ialu_overflow  = ready ? m_of   : 1'b1;
  assign ialu_underflow = ready ? m_uf   : 1'b1;

  always #5 iclock = ~iclock;

  fpalu_seq dut (
    .iclock(iclock), .ireset(ireset), .istart(istart), .icontrol(icontrol),
    .idataa(idataa), .idatab(idatab), .ocontrol(ocontrol), .odataa(odataa),
    .odatab(odatab), .ialu_result(ialu_result), .ialu_nan(ialu_nan),
    .ialu_overflow(ialu_overflow), .ialu_underflow(ialu_underflow),
    .ialu_comp(ialu_comp), .obusy(obusy), .odone(odone), .oresult(oresult),
    .ocomp(ocomp), .iflagclr(iflagclr), .oflags(oflags)
  );

  function automatic int lat_of(input logic [4:0] op);
    case (op)
      FOPADD, FOPSUB:         return 7;
      FOPMUL:                 return 5;
      FOPDIV:                 return 6;
      FOPSQRT:                return 16;
      FOPCEQ, FOPCLT, FOPCLE: return 1;
      FOPCVTSW, FOPCVTWS:     return 6;
      default:                return 0;
    endcase
  endfunction

  always @(negedge iclock) begin
    if (odone) begin
      if (sb.size() == 0) begin
        failures++; checks++;
        $display("FAIL spurious_done at cycle %0d: odone=1, required 0", cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        checks += 4;
        if (cyc !== e.cyc) begin
          failures++;
          $display("FAIL done_cycle: odone at %0d, required %0d", cyc, e.cyc);
        end
        if (oresult !== e.res) begin
          failures++;
          $display("FAIL oresult: got %h, required %h", oresult, e.res);
        end
        if (ocomp !== e.comp) begin
          failures++;
          $display("FAIL ocomp: got %b, required %b", ocomp, e.comp);
        end
        if (oflags !== e.flags) begin
          failures++;
          $display("FAIL oflags_at_done: got %b, required %b", oflags, e.flags);
        end
      end
    end
  end

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic comp, input logic nan,
                        input logic of, input logic uf, input int clr_at, input int repulse_at);
    int l, c0;
    logic [2:0] nf;
    sb_t e;
    l = lat_of(op);
    @(negedge iclock);
    m_res = res; m_comp = comp; m_nan = nan; m_of = of; m_uf = uf; cur_lat = l;
    istart = 1'b1; icontrol = op; idataa = a; idatab = b;
    c0 = cyc;
    nf = 3'b000;
    if (op == FOPADD || op == FOPSUB || op == FOPMUL || op == FOPDIV || op == FOPCVTWS)
      nf = {nan, of, uf};
    else if (op == FOPSQRT)
      nf = {nan, of, 1'b0};
    if (clr_at == l + 1) exp_flags = nf;
    else                 exp_flags = exp_flags | nf;
    e.res = res; e.comp = comp; e.flags = FLAGS_EN ? exp_flags : 3'b000; e.cyc = c0 + l + 2;
    sb.push_back(e);
    for (int k = 1; k <= l + 3; k++) begin
      @(negedge iclock);
      istart   = (k == repulse_at);
      iflagclr = (k == clr_at);
      if (k == repulse_at) begin
        icontrol = FOPSQRT; idataa = 32'h12345678; idatab = 32'h9ABCDEF0;
      end
      checks++;
      if (obusy !== (k <= l + 1 + 1)) begin
        failures++;
        $display("FAIL obusy op=%0d offset=%0d: got %b, required %b", op, k, obusy, k <= l + 2);
      end
      if (k <= l + 2) begin
        checks++;
        if (ocontrol !== op || odataa !== a || odatab !== b) begin
          failures++;
          $display("FAIL operand_hold offset=%0d: got %h/%h/%h, required %h/%h/%h",
                   k, ocontrol, odataa, odatab, op, a, b);
        end
      end
    end
    istart = 1'b0; iflagclr = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL done_timeout op=%0d: %0d pending, required 0", op, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({ocontrol, odataa, odatab, oresult, ocomp, odone, obusy, oflags} !== '0) begin
      failures++;
      $display("FAIL %s: ctl=%h a=%h b=%h res=%h comp=%b done=%b busy=%b flags=%b, required all 0",
               tag, ocontrol, odataa, odatab, oresult, ocomp, odone, obusy, oflags);
    end
  endtask

  task automatic test_reset();
    ireset = 1'b1; istart = 1'b0; icontrol = 5'd0; idataa = 32'd0; idatab = 32'd0;
    iflagclr = 1'b0; m_res = 32'd0; m_comp = 1'b0; m_nan = 1'b0; m_of = 1'b0; m_uf = 1'b0;
    repeat (3) @(negedge iclock);
    check_outputs_zero("reset_state");
    ireset = 1'b0;
    @(negedge iclock);
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_add();
    run_op(FOPADD, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    checks++;
    if (oflags !== 3'b000) begin
      failures++; $display("FAIL add_flags: got %b, required 000", oflags);
    end
  endtask

  task automatic test_neg();
    run_op(FOPNEG, 32'h40490FDB, 32'h0, 32'hC0490FDB, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
  endtask

  task automatic test_mul_clt();
    run_op(FOPMUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    run_op(FOPCLT, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
    checks++;
    if (oflags !== (FLAGS_EN ? 3'b010 : 3'b000)) begin
      failures++; $display("FAIL sticky_of: got %b, required %b", oflags, FLAGS_EN ? 3'b010 : 3'b000);
    end
  endtask

  task automatic test_sqrt_reset();
    @(negedge iclock);
    m_res = 32'h3FB504F3; cur_lat = 16;
    istart = 1'b1; icontrol = FOPSQRT; idataa = 32'h40000000; idatab = 32'h0;
    repeat (5) begin
      @(negedge iclock);
      istart = 1'b0;
    end
    checks++;
    if (obusy !== 1'b1) begin
      failures++; $display("FAIL sqrt_inflight: obusy=%b, required 1", obusy);
    end
    #2 ireset = 1'b1;
    #1 check_outputs_zero("midop_reset");
    @(negedge iclock);
    ireset = 1'b0;
    exp_flags = 3'b000;
    repeat (25) @(negedge iclock);
    check_outputs_zero("no_done_after_reset");
    run_op(FOPADD, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_div_flagclr();
    run_op(FOPDIV, 32'h0, 32'h0, 32'h7FC00000, 1'b0, 1'b1, 1'b0, 1'b0, 7, -1);
    checks++;
    if (oflags !== (FLAGS_EN ? 3'b100 : 3'b000)) begin
      failures++; $display("FAIL set_wins: got %b, required %b", oflags, FLAGS_EN ? 3'b100 : 3'b000);
    end
    @(negedge iclock); iflagclr = 1'b1;
    @(negedge iclock); iflagclr = 1'b0;
    exp_flags = 3'b000;
    checks++;
    if (oflags !== 3'b000) begin
      failures++; $display("FAIL flag_clear: got %b, required 000", oflags);
    end
  endtask

  task automatic test_back_to_back();
    run_op(FOPCVTWS, 32'h3F800000, 32'h0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3);
    run_op(FOPSUB, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op(5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_neg();
    test_mul_clt();
    test_sqrt_reset();
    test_div_flagclr();
    test_back_to_back();
    repeat (3) @(negedge iclock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
